// File: rtl/mlu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, read selects,
// FSM states and the HI/LO pair type.
package mlu_pkg;

   localparam logic [4:0] MLU_NONE  = 5'd0;
   localparam logic [4:0] MLU_mult  = 5'd1;
   localparam logic [4:0] MLU_multu = 5'd2;
   localparam logic [4:0] MLU_div   = 5'd3;
   localparam logic [4:0] MLU_divu  = 5'd4;
   localparam logic [4:0] MLU_mthi  = 5'd5;
   localparam logic [4:0] MLU_mtlo  = 5'd6;

   localparam logic [2:0] MLU_OUT_NONE = 3'd0;
   localparam logic [2:0] MLU_OUT_HI   = 3'd1;
   localparam logic [2:0] MLU_OUT_LO   = 3'd2;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } mlu_state_e;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } hilo_t;

endpackage

// File: rtl/mlu_arith.sv
// Combinational arithmetic for the MLU: signed/unsigned 64-bit products and
// MIPS-style quotient/remainder including divide-by-zero and overflow results.
module mlu_arith
   import mlu_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output hilo_t       o_mulS,
   output hilo_t       o_mulU,
   output hilo_t       o_divS,
   output hilo_t       o_divU
);

   logic signed [63:0] w_aExt;
   logic signed [63:0] w_bExt;
   logic signed [63:0] w_prodS;
   logic [63:0]        w_prodU;
   logic               w_divZero;
   logic               w_divOvf;
   logic [31:0]        w_divisorU;
   logic [31:0]        w_quoU;
   logic [31:0]        w_remU;
   logic [31:0]        w_aMag;
   logic [31:0]        w_bMag;
   logic [31:0]        w_bMagSafe;
   logic [31:0]        w_quoMag;
   logic [31:0]        w_remMag;
   logic [31:0]        w_quoS;
   logic [31:0]        w_remS;

   assign w_aExt  = $signed({{32{i_a[31]}}, i_a});
   assign w_bExt  = $signed({{32{i_b[31]}}, i_b});
   assign w_prodS = w_aExt * w_bExt;
   assign w_prodU = {32'd0, i_a} * {32'd0, i_b};

   assign w_divZero  = (i_b == 32'd0);
   assign w_divOvf   = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
   assign w_divisorU = w_divZero ? 32'd1 : i_b;
   assign w_quoU     = i_a / w_divisorU;
   assign w_remU     = i_a % w_divisorU;

   // Signed division works on magnitudes so the quotient truncates toward
   // zero and the remainder follows the dividend's sign.
   assign w_aMag     = i_a[31] ? (32'd0 - i_a) : i_a;
   assign w_bMag     = i_b[31] ? (32'd0 - i_b) : i_b;
   assign w_bMagSafe = w_divZero ? 32'd1 : w_bMag;
   assign w_quoMag   = w_aMag / w_bMagSafe;
   assign w_remMag   = w_aMag % w_bMagSafe;
   assign w_quoS     = (i_a[31] ^ i_b[31]) ? (32'd0 - w_quoMag) : w_quoMag;
   assign w_remS     = i_a[31] ? (32'd0 - w_remMag) : w_remMag;

   assign o_mulS = $unsigned(w_prodS);
   assign o_mulU = w_prodU;

   always_comb begin
      o_divU = '{hi: w_remU, lo: w_quoU};
      o_divS = '{hi: w_remS, lo: w_quoS};
      if (w_divZero) begin
         o_divU = '{hi: i_a, lo: 32'hFFFF_FFFF};
         o_divS = '{hi: i_a, lo: 32'hFFFF_FFFF};
      end else if (w_divOvf) begin
         o_divS = '{hi: 32'd0, lo: 32'h8000_0000};
      end
   end

endmodule

// File: rtl/mlu_core.sv
// EX-stage multiply/divide unit: owns HI/LO, holds results back for a fixed
// latency and raises busy so the hazard unit can stall MLU users.
module mlu_core
   import mlu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [4:0]  mlu_op,
   input  logic [2:0]  mlu_out,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mlu_res,
   output logic        ovl_err
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   mlu_state_e       r_state;
   mlu_state_e       w_stateNext;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cntNext;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic [31:0]      w_hiNext;
   logic [31:0]      w_loNext;
   hilo_t            r_pend;
   hilo_t            w_pendNext;
   logic             r_ovl;
   logic             w_ovlNext;
   hilo_t            w_mulS;
   hilo_t            w_mulU;
   hilo_t            w_divS;
   hilo_t            w_divU;

   mlu_arith u_arith (
      .i_a    (src_a),
      .i_b    (src_b),
      .o_mulS (w_mulS),
      .o_mulU (w_mulU),
      .o_divS (w_divS),
      .o_divU (w_divU)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
         r_pend  <= '0;
         r_ovl   <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         r_cnt   <= w_cntNext;
         r_hi    <= w_hiNext;
         r_lo    <= w_loNext;
         r_pend  <= w_pendNext;
         r_ovl   <= w_ovlNext;
      end
   end

   // Operands are captured into the pending pair at the start edge; HI/LO
   // only change when the countdown expires or on an mthi/mtlo.
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_hiNext    = r_hi;
      w_loNext    = r_lo;
      w_pendNext  = r_pend;
      w_ovlNext   = r_ovl;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               case (mlu_op)
                  MLU_mult: begin
                     w_pendNext  = w_mulS;
                     w_cntNext   = CNT_W'(MULT_CYCLES);
                     w_stateNext = S_BUSY;
                  end
                  MLU_multu: begin
                     w_pendNext  = w_mulU;
                     w_cntNext   = CNT_W'(MULT_CYCLES);
                     w_stateNext = S_BUSY;
                  end
                  MLU_div: begin
                     w_pendNext  = w_divS;
                     w_cntNext   = CNT_W'(DIV_CYCLES);
                     w_stateNext = S_BUSY;
                  end
                  MLU_divu: begin
                     w_pendNext  = w_divU;
                     w_cntNext   = CNT_W'(DIV_CYCLES);
                     w_stateNext = S_BUSY;
                  end
                  MLU_mthi: w_hiNext = src_a;
                  MLU_mtlo: w_loNext = src_a;
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            if (start) begin
               w_ovlNext = 1'b1;
            end
            w_cntNext = r_cnt - 1'b1;
            if (r_cnt <= CNT_W'(1)) begin
               w_cntNext   = '0;
               w_hiNext    = r_pend.hi;
               w_loNext    = r_pend.lo;
               w_stateNext = S_IDLE;
            end
         end
         default: w_stateNext = S_IDLE;
      endcase
   end

   assign busy    = (r_state == S_BUSY);
   assign hi      = r_hi;
   assign lo      = r_lo;
   assign ovl_err = r_ovl;
   assign mlu_res = (mlu_out == MLU_OUT_HI) ? r_hi :
                    (mlu_out == MLU_OUT_LO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mlu_core.sv
// Directed, table-driven bench for mlu_core: latency, HI/LO results and
// the overlap, mthi/mtlo and mid-operation reset corner cases.
module tb_mlu_core;
   import mlu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [4:0]  mlu_op;
   logic [2:0]  mlu_out;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mlu_res;
   logic        ovl_err;

   int checks;
   int failures;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          cycles;
      logic [31:0] expHi;
      logic [31:0] expLo;
   } vec_t;

   vec_t vecs[10];

   mlu_core #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .mlu_op  (mlu_op),
      .mlu_out (mlu_out),
      .src_a   (src_a),
      .src_b   (src_b),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo),
      .mlu_res (mlu_res),
      .ovl_err (ovl_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // One-cycle start pulse driven from a falling edge; returns at the
   // falling edge after the start edge.
   task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start  = 1'b1;
      mlu_op = op;
      src_a  = a;
      src_b  = b;
      @(negedge clk);
      start  = 1'b0;
      mlu_op = MLU_NONE;
   endtask

   task automatic waitIdle(input string name, output int busyCycles, input logic [31:0] oldHi,
                           input logic [31:0] oldLo, output logic holdOk);
      busyCycles = 0;
      holdOk     = 1'b1;
      while (busy === 1'b1 && busyCycles < 100) begin
         busyCycles++;
         if (hi !== oldHi || lo !== oldLo || mlu_res !== oldLo) holdOk = 1'b0;
         src_a = $urandom;
         src_b = $urandom;
         @(negedge clk);
      end
      if (busyCycles >= 100) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s timeout: busy still 1 after 100 cycles, required 0", name);
      end
   endtask

   initial begin
      int          busyCycles;
      logic        holdOk;
      logic [31:0] oldHi;
      logic [31:0] oldLo;

      checks   = 0;
      failures = 0;

      vecs[0] = '{MLU_mult,  32'hFFFF_FFFF, 32'd2,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[1] = '{MLU_multu, 32'hFFFF_FFFF, 32'd2,         5,  32'h0000_0001, 32'hFFFF_FFFE};
      vecs[2] = '{MLU_div,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{MLU_divu,  32'd7,         32'd2,         10, 32'h0000_0001, 32'h0000_0003};
      vecs[4] = '{MLU_divu,  32'h0000_1234, 32'd0,         10, 32'h0000_1234, 32'hFFFF_FFFF};
      vecs[5] = '{MLU_div,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
      vecs[6] = '{MLU_div,   32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[7] = '{MLU_div,   32'hFFFF_FFFB, 32'd0,         10, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
      vecs[8] = '{MLU_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001};
      vecs[9] = '{MLU_mult,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'h0000_0000, 32'h0000_0001};

      rst_n   = 1'b0;
      start   = 1'b0;
      mlu_op  = MLU_NONE;
      mlu_out = MLU_OUT_LO;
      src_a   = 32'd0;
      src_b   = 32'd0;
      #22;
      rst_n = 1'b1;
      @(negedge clk);

      checkOutput("reset hi", hi, 32'd0);
      checkOutput("reset lo", lo, 32'd0);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      checkOutput("reset ovl_err", {31'd0, ovl_err}, 32'd0);
      checkOutput("reset mlu_res", mlu_res, 32'd0);

      for (int i = 0; i < 10; i++) begin
         oldHi = hi;
         oldLo = lo;
         mlu_out = MLU_OUT_LO;
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
         waitIdle($sformatf("vec%0d", i), busyCycles, oldHi, oldLo, holdOk);
         checkOutput($sformatf("vec%0d busy cycles", i), 32'(busyCycles), 32'(vecs[i].cycles));
         checkOutput($sformatf("vec%0d hold during busy", i), {31'd0, holdOk}, 32'd1);
         checkOutput($sformatf("vec%0d hi", i), hi, vecs[i].expHi);
         checkOutput($sformatf("vec%0d lo", i), lo, vecs[i].expLo);
         checkOutput($sformatf("vec%0d mlu_res LO", i), mlu_res, vecs[i].expLo);
         mlu_out = MLU_OUT_HI;
         #1;
         checkOutput($sformatf("vec%0d mlu_res HI", i), mlu_res, vecs[i].expHi);
      end

      mlu_out = MLU_OUT_NONE;
      #1;
      checkOutput("mlu_res none", mlu_res, 32'd0);
      mlu_out = 3'd3;
      #1;
      checkOutput("mlu_res sel3", mlu_res, 32'd0);

      // Back-to-back mthi then mtlo: each lands on its own edge, no busy.
      @(negedge clk);
      start  = 1'b1;
      mlu_op = MLU_mthi;
      src_a  = 32'hDEAD_BEEF;
      @(negedge clk);
      checkOutput("mthi hi", hi, 32'hDEAD_BEEF);
      checkOutput("mthi busy", {31'd0, busy}, 32'd0);
      mlu_op = MLU_mtlo;
      src_a  = 32'h0BAD_F00D;
      @(negedge clk);
      start  = 1'b0;
      mlu_op = MLU_NONE;
      checkOutput("mtlo lo", lo, 32'h0BAD_F00D);
      checkOutput("mtlo hi kept", hi, 32'hDEAD_BEEF);
      checkOutput("mtlo busy", {31'd0, busy}, 32'd0);

      // Unknown op with start does nothing.
      applyStimulus(5'd9, 32'h1111_1111, 32'h2222_2222);
      checkOutput("bad op busy", {31'd0, busy}, 32'd0);
      checkOutput("bad op hi", hi, 32'hDEAD_BEEF);
      checkOutput("bad op lo", lo, 32'h0BAD_F00D);

      // Start pulse during BUSY is ignored but flagged.
      mlu_out = MLU_OUT_LO;
      applyStimulus(MLU_mult, 32'd3, 32'd4);
      checkOutput("ovl pre busy", {31'd0, busy}, 32'd1);
      start  = 1'b1;
      mlu_op = MLU_mthi;
      src_a  = 32'h5555_5555;
      @(negedge clk);
      start  = 1'b0;
      mlu_op = MLU_NONE;
      checkOutput("ovl_err set", {31'd0, ovl_err}, 32'd1);
      checkOutput("ovl hi untouched", hi, 32'hDEAD_BEEF);
      oldHi = hi;
      oldLo = lo;
      waitIdle("ovl wait", busyCycles, oldHi, oldLo, holdOk);
      checkOutput("ovl busy total", 32'(busyCycles + 1), 32'd5);
      checkOutput("ovl hi", hi, 32'd0);
      checkOutput("ovl lo", lo, 32'd12);
      checkOutput("ovl_err sticky", {31'd0, ovl_err}, 32'd1);

      // Asynchronous reset in the third busy cycle aborts the multiply.
      applyStimulus(MLU_mult, 32'hFFFF_FFFF, 32'd2);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst pre busy", {31'd0, busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst busy", {31'd0, busy}, 32'd0);
      checkOutput("rst hi", hi, 32'd0);
      checkOutput("rst lo", lo, 32'd0);
      checkOutput("rst ovl_err", {31'd0, ovl_err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("post rst busy", {31'd0, busy}, 32'd0);
      checkOutput("post rst lo", lo, 32'd0);
      checkOutput("post rst hi", hi, 32'd0);
      applyStimulus(MLU_mthi, 32'hCAFE_1234, 32'd0);
      checkOutput("post rst mthi", hi, 32'hCAFE_1234);
      checkOutput("post rst mthi busy", {31'd0, busy}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
